// File: rtl/poly_player_pkg.sv
// rtl/poly_player_pkg.sv - shared note table, message codes and message decode for the players
package poly_player_pkg;

  localparam int         NOTE_MAX    = 39;
  localparam int         NOTE_W      = 7;
  localparam logic [7:0] MSG_ALL_OFF = 8'h7F;

  localparam logic [0:0] VOICE_IDLE   = 1'b0;
  localparam logic [0:0] VOICE_ACTIVE = 1'b1;

  typedef struct packed {
    logic              on;
    logic              off;
    logic              all_off;
    logic [NOTE_W-1:0] id;
  } msg_dec_t;

  // 13 keys (C..C') per range, three ranges: octave 3, 4 and 5; values in centi-Hz
  function automatic int note_centi_hz(input int id);
    case (id)
      0:  return 13081;   1: return 13859;   2: return 14683;   3: return 15556;
      4:  return 16481;   5: return 17461;   6: return 18500;   7: return 19600;
      8:  return 20765;   9: return 22000;  10: return 23308;  11: return 24694;
      12: return 26163;  13: return 26163;  14: return 27718;  15: return 29366;
      16: return 31113;  17: return 32963;  18: return 34923;  19: return 36999;
      20: return 39200;  21: return 41530;  22: return 44000;  23: return 46616;
      24: return 49388;  25: return 52325;  26: return 52325;  27: return 55437;
      28: return 58733;  29: return 62225;  30: return 65926;  31: return 69846;
      32: return 73999;  33: return 78399;  34: return 83061;  35: return 88000;
      36: return 93233;  37: return 98777;  38: return 104650;
      default: return 0;
    endcase
  endfunction

  // Phase increment round(f * 2^acc_w / clk_freq); only ever evaluated on constants
  function automatic logic [63:0] note_inc(input int id, input int clk_freq, input int acc_w);
    logic [63:0] num;
    logic [63:0] den;
    num = 64'(note_centi_hz(id)) << acc_w;
    den = 64'(clk_freq) * 64'd100;
    return (num + (den >> 1)) / den;
  endfunction

  // Split a raw message into note-on / note-off / all-off, dropping out-of-range ids
  function automatic msg_dec_t msg_decode(input logic valid, input logic [7:0] m);
    msg_dec_t d;
    d.id      = m[NOTE_W-1:0];
    d.all_off = valid && (m == MSG_ALL_OFF);
    d.on      = valid && m[7] && (m[NOTE_W-1:0] < NOTE_W'(NOTE_MAX));
    d.off     = valid && !m[7] && (m[NOTE_W-1:0] < NOTE_W'(NOTE_MAX));
    return d;
  endfunction

endpackage

// File: rtl/poly_player_if.sv
// rtl/poly_player_if.sv - message input and audio/display outputs of the polyphonic player
interface poly_player_if
  import poly_player_pkg::*;
#(
  parameter int NUM_VOICES = 4
);
  logic                  msg_valid;
  logic [7:0]            msg;
  logic                  wave;
  logic [NUM_VOICES-1:0] active_mask;
  logic [NOTE_W-1:0]     last_note;
  logic                  steal;

  modport master (
    output msg_valid, msg,
    input  wave, active_mask, last_note, steal
  );

  modport slave (
    input  msg_valid, msg,
    output wave, active_mask, last_note, steal
  );
endinterface

// File: rtl/poly_player_voice.sv
// rtl/poly_player_voice.sv - one square-wave voice: state, phase accumulator, auto-release timer
module poly_player_voice
  import poly_player_pkg::*;
#(
  parameter int ACC_W      = 32,
  parameter int TIMEOUT_MS = 2000
) (
  input  logic              pllclk,
  input  logic              rst,
  input  logic              alloc_i,
  input  logic              retrig_i,
  input  logic              release_i,
  input  logic              tick_i,
  input  logic [NOTE_W-1:0] note_i,
  input  logic [ACC_W-1:0]  inc_i,
  output logic              active_o,
  output logic [NOTE_W-1:0] note_o,
  output logic              square_o
);
  localparam int             TW  = (TIMEOUT_MS > 0) ? $clog2(TIMEOUT_MS + 1) : 1;
  localparam logic [TW-1:0]  TMO = TW'(TIMEOUT_MS);

  logic [0:0]        state_q, state_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [ACC_W-1:0]  inc_q, inc_d;
  logic [ACC_W-1:0]  phase_q, phase_d;
  logic [TW-1:0]     timer_q, timer_d;

  // Messages take priority over the running oscillator and over a timeout in the same cycle
  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    inc_d   = inc_q;
    phase_d = phase_q;
    timer_d = timer_q;
    if (alloc_i) begin
      state_d = VOICE_ACTIVE;
      note_d  = note_i;
      inc_d   = inc_i;
      phase_d = '0;
      timer_d = '0;
    end else if (retrig_i) begin
      phase_d = '0;
      timer_d = '0;
    end else if (release_i) begin
      state_d = VOICE_IDLE;
      phase_d = '0;
      timer_d = '0;
    end else if (state_q == VOICE_ACTIVE) begin
      phase_d = phase_q + inc_q;
      if ((TIMEOUT_MS != 0) && tick_i) begin
        if (timer_q == TMO - TW'(1)) begin
          state_d = VOICE_IDLE;
          phase_d = '0;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
    end
  end

  // Voice registers
  always_ff @(posedge pllclk or posedge rst) begin
    if (rst) begin
      state_q <= VOICE_IDLE;
      note_q  <= '0;
      inc_q   <= '0;
      phase_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      inc_q   <= inc_d;
      phase_q <= phase_d;
      timer_q <= timer_d;
    end
  end

  assign active_o = (state_q == VOICE_ACTIVE);
  assign note_o   = note_q;
  assign square_o = (state_q == VOICE_ACTIVE) && phase_q[ACC_W-1];

endmodule

// File: rtl/poly_player.sv
// rtl/poly_player.sv - polyphonic note player: voice allocator, ms prescaler, sigma-delta mixer
module poly_player
  import poly_player_pkg::*;
#(
  parameter int CLK_FREQ   = 120_000_000,
  parameter int NUM_VOICES = 4,
  parameter int ACC_W      = 32,
  parameter int TIMEOUT_MS = 2000
) (
  input  logic         pllclk,
  input  logic         rst,
  poly_player_if.slave bus
);
  localparam int PW  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int SW  = $clog2(NUM_VOICES + 1);
  localparam int AW  = SW + 1;
  localparam int PRE = (CLK_FREQ / 1000 > 0) ? CLK_FREQ / 1000 : 1;
  localparam int CW  = (PRE > 1) ? $clog2(PRE) : 1;

  msg_dec_t              dec;
  logic [ACC_W-1:0]      inc_rom [NOTE_MAX];
  logic [ACC_W-1:0]      inc_sel;
  logic [NUM_VOICES-1:0] active, square, match, alloc, retrig, rel_v;
  logic [NOTE_W-1:0]     voice_note [NUM_VOICES];
  logic                  any_free;
  logic [PW-1:0]         free_idx;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic                  steal_q, steal_d;
  logic [NOTE_W-1:0]     last_q, last_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  tick;
  logic [SW-1:0]         sum;
  logic [AW-1:0]         acc_q, acc_d, acc_sum;
  logic                  wave_q, wave_d;

  for (genvar n = 0; n < NOTE_MAX; n++) begin : g_rom
    assign inc_rom[n] = ACC_W'(note_inc(n, CLK_FREQ, ACC_W));
  end

  // Allocator: retrigger a matching voice, else lowest idle voice, else steal round-robin
  always_comb begin
    dec      = msg_decode(bus.msg_valid, bus.msg);
    match    = '0;
    any_free = 1'b0;
    free_idx = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      match[v] = active[v] && (voice_note[v] == dec.id);
      if (!active[v]) begin
        any_free = 1'b1;
        free_idx = PW'(v);
      end
    end
    inc_sel = '0;
    for (int n = 0; n < NOTE_MAX; n++) begin
      if (dec.id == NOTE_W'(n)) inc_sel = inc_rom[n];
    end
    alloc   = '0;
    retrig  = '0;
    rel_v   = '0;
    ptr_d   = ptr_q;
    steal_d = 1'b0;
    last_d  = last_q;
    if (dec.on) begin
      last_d = dec.id;
      if (|match) begin
        retrig = match;
      end else if (any_free) begin
        alloc[free_idx] = 1'b1;
      end else begin
        alloc[ptr_q] = 1'b1;
        steal_d      = 1'b1;
        ptr_d        = (ptr_q == PW'(NUM_VOICES - 1)) ? '0 : ptr_q + PW'(1);
      end
    end
    if (dec.all_off) rel_v = '1;
    else if (dec.off) rel_v = match;
  end

  // Allocator state and display outputs
  always_ff @(posedge pllclk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      steal_q <= 1'b0;
      last_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      steal_q <= steal_d;
      last_q  <= last_d;
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    poly_player_voice #(
      .ACC_W      (ACC_W),
      .TIMEOUT_MS (TIMEOUT_MS)
    ) u_voice (
      .pllclk    (pllclk),
      .rst       (rst),
      .alloc_i   (alloc[v]),
      .retrig_i  (retrig[v]),
      .release_i (rel_v[v]),
      .tick_i    (tick),
      .note_i    (dec.id),
      .inc_i     (inc_sel),
      .active_o  (active[v]),
      .note_o    (voice_note[v]),
      .square_o  (square[v])
    );
  end

  // Free-running millisecond prescaler shared by all voice timers
  always_comb begin
    tick  = (cnt_q == CW'(PRE - 1));
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  // Prescaler counter
  always_ff @(posedge pllclk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // First-order sigma-delta: density of ones equals sounding voices / NUM_VOICES
  always_comb begin
    sum = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      sum = sum + SW'(square[v]);
    end
    acc_sum = acc_q + AW'(sum);
    if (acc_sum >= AW'(NUM_VOICES)) begin
      wave_d = 1'b1;
      acc_d  = acc_sum - AW'(NUM_VOICES);
    end else begin
      wave_d = 1'b0;
      acc_d  = acc_sum;
    end
  end

  // Mixer registers
  always_ff @(posedge pllclk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      wave_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      wave_q <= wave_d;
    end
  end

  assign bus.wave        = wave_q;
  assign bus.active_mask = active;
  assign bus.last_note   = last_q;
  assign bus.steal       = steal_q;

endmodule

// File: tb/tb_poly_player.sv
// tb/tb_poly_player.sv - directed vector and sequence bench for poly_player
module tb_poly_player;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  poly_player_if #(.NUM_VOICES(4)) bus_a ();
  poly_player_if #(.NUM_VOICES(4)) bus_b ();

  poly_player #(
    .CLK_FREQ   (100_000),
    .NUM_VOICES (4),
    .ACC_W      (32),
    .TIMEOUT_MS (0)
  ) dut_a (
    .pllclk (clk),
    .rst    (rst),
    .bus    (bus_a)
  );

  poly_player #(
    .CLK_FREQ   (10_000),
    .NUM_VOICES (4),
    .ACC_W      (32),
    .TIMEOUT_MS (2)
  ) dut_b (
    .pllclk (clk),
    .rst    (rst),
    .bus    (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] msg;
    logic [3:0] mask;
    logic [6:0] last;
    logic       steal;
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: actual=%0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Called at a negedge; the message is sampled on the next rising edge
  task automatic strobe(input bit sel_b, input logic [7:0] m);
    if (sel_b) begin bus_b.msg_valid = 1'b1; bus_b.msg = m; end
    else       begin bus_a.msg_valid = 1'b1; bus_a.msg = m; end
    @(negedge clk);
    bus_a.msg_valid = 1'b0;
    bus_b.msg_valid = 1'b0;
  endtask

  task automatic strobe_at(input bit sel_b, input int edge_no, input logic [7:0] m);
    wait_until(edge_no - 1);
    strobe(sel_b, m);
  endtask

  task automatic wait_wave(input int limit, output int n);
    n = 0;
    while (bus_a.wave !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n, t1, t2, ones, e0, d, x0, x1;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus_a.msg_valid = 1'b0; bus_a.msg = 8'h00;
    bus_b.msg_valid = 1'b0; bus_b.msg = 8'h00;

    vecs[0]  = '{8'h81, 4'b0001, 7'd1,  1'b0};
    vecs[1]  = '{8'h82, 4'b0011, 7'd2,  1'b0};
    vecs[2]  = '{8'h83, 4'b0111, 7'd3,  1'b0};
    vecs[3]  = '{8'h84, 4'b1111, 7'd4,  1'b0};
    vecs[4]  = '{8'h86, 4'b1111, 7'd6,  1'b1};
    vecs[5]  = '{8'h06, 4'b1110, 7'd6,  1'b0};
    vecs[6]  = '{8'h87, 4'b1111, 7'd7,  1'b0};
    vecs[7]  = '{8'h88, 4'b1111, 7'd8,  1'b1};
    vecs[8]  = '{8'h02, 4'b1111, 7'd8,  1'b0};
    vecs[9]  = '{8'h08, 4'b1101, 7'd8,  1'b0};
    vecs[10] = '{8'hFF, 4'b1101, 7'd8,  1'b0};
    vecs[11] = '{8'hA7, 4'b1101, 7'd8,  1'b0};
    vecs[12] = '{8'h27, 4'b1101, 7'd8,  1'b0};
    vecs[13] = '{8'h88, 4'b1111, 7'd8,  1'b0};
    vecs[14] = '{8'h83, 4'b1111, 7'd3,  1'b0};
    vecs[15] = '{8'h7F, 4'b0000, 7'd3,  1'b0};
    vecs[16] = '{8'h0A, 4'b0000, 7'd3,  1'b0};
    vecs[17] = '{8'hA6, 4'b0001, 7'd38, 1'b0};
    vecs[18] = '{8'h7F, 4'b0000, 7'd38, 1'b0};

    // reset state
    do_reset();
    chk("rst_wave", 32'(bus_a.wave), 0);
    chk("rst_mask", 32'(bus_a.active_mask), 0);
    chk("rst_last", 32'(bus_a.last_note), 0);
    chk("rst_steal", 32'(bus_a.steal), 0);
    chk("rst_mask_b", 32'(bus_b.active_mask), 0);

    // single note 5: F3 at 100 kHz gives inc 7499442, square high from edge 287 to 572
    strobe(1'b0, 8'h85);
    chk("n5_mask", 32'(bus_a.active_mask), 32'b0001);
    chk("n5_last", 32'(bus_a.last_note), 5);
    wait_wave(400, n);
    chk_range("n5_first_high", n, 288, 294);
    t1 = cyc;
    ones = 0;
    for (int i = 0; i < 400; i++) begin
      if (bus_a.wave === 1'b1) ones++;
      @(negedge clk);
    end
    chk_range("n5_density_ones", ones, 69, 73);
    wait_wave(400, n);
    t2 = cyc;
    chk_range("n5_period", t2 - t1, 567, 579);

    // allocation / steal / release vectors, back-to-back
    do_reset();
    for (int i = 0; i < 19; i++) begin
      strobe(1'b0, vecs[i].msg);
      chk($sformatf("vec%0d_mask", i), 32'(bus_a.active_mask), 32'(vecs[i].mask));
      chk($sformatf("vec%0d_last", i), 32'(bus_a.last_note), 32'(vecs[i].last));
      chk($sformatf("vec%0d_steal", i), 32'(bus_a.steal), 32'(vecs[i].steal));
    end

    // retrigger 100 cycles apart restarts the phase
    do_reset();
    strobe(1'b0, 8'h85);
    e0 = cyc;
    strobe_at(1'b0, e0 + 100, 8'h85);
    chk("retrig_mask", 32'(bus_a.active_mask), 32'b0001);
    chk("retrig_steal", 32'(bus_a.steal), 0);
    chk("retrig_last", 32'(bus_a.last_note), 5);
    wait_wave(400, n);
    chk_range("retrig_first_high", n, 288, 294);

    // note-off of one note in a pair, then all-off
    do_reset();
    strobe(1'b0, 8'h85);
    strobe(1'b0, 8'h87);
    strobe(1'b0, 8'h05);
    chk("off5_mask", 32'(bus_a.active_mask), 32'b0010);
    repeat (400) @(negedge clk);
    strobe(1'b0, 8'h7F);
    chk("alloff_mask", 32'(bus_a.active_mask), 0);
    chk("alloff_last", 32'(bus_a.last_note), 7);
    @(negedge clk);
    ones = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus_a.wave !== 1'b0) ones++;
      @(negedge clk);
    end
    chk("alloff_wave_quiet", 32'(ones), 0);

    // timeout on dut_b: 10-cycle ms tick, two ticks
    strobe(1'b1, 8'h89);
    e0 = cyc;
    chk("tmo_mask_on", 32'(bus_b.active_mask), 32'b0001);
    chk("tmo_last", 32'(bus_b.last_note), 9);
    d = 0;
    while (bus_b.active_mask[0] === 1'b1 && d < 40) begin
      @(negedge clk);
      d++;
    end
    chk_range("tmo_cycles", d, 10, 21);
    // note-off landing on the timeout edge
    x0 = e0 + 50;
    strobe_at(1'b1, x0, 8'h89);
    wait_until(x0 + d - 1);
    chk("tmo_off_pre", 32'(bus_b.active_mask), 32'b0001);
    strobe_at(1'b1, x0 + d, 8'h09);
    chk("tmo_off_mask", 32'(bus_b.active_mask), 0);
    ones = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus_b.active_mask !== 4'b0000 || bus_b.wave !== 1'b0 || bus_b.steal !== 1'b0) ones++;
      @(negedge clk);
    end
    chk("tmo_off_quiet", 32'(ones), 0);
    // retrigger landing on the timeout edge restarts the timer
    x1 = x0 + 80;
    strobe_at(1'b1, x1, 8'h89);
    strobe_at(1'b1, x1 + d, 8'h89);
    chk("tmo_retrig_mask", 32'(bus_b.active_mask), 32'b0001);
    n = 0;
    while (bus_b.active_mask[0] === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk_range("tmo_retrig_cycles", n, 19, 21);

    // invalid note-on leaves a chord untouched; async reset clears at once
    do_reset();
    strobe(1'b0, 8'h81);
    strobe(1'b0, 8'h82);
    strobe(1'b0, 8'h83);
    ones = 0;
    for (int i = 0; i < 400; i++) begin
      if (bus_a.wave === 1'b1) ones++;
      @(negedge clk);
    end
    chk_range("chord_wave_ones", ones, 1, 400);
    strobe(1'b0, 8'hFF);
    chk("inv_mask", 32'(bus_a.active_mask), 32'b0111);
    chk("inv_last", 32'(bus_a.last_note), 3);
    chk("inv_steal", 32'(bus_a.steal), 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_mask", 32'(bus_a.active_mask), 0);
    chk("arst_last", 32'(bus_a.last_note), 0);
    chk("arst_wave", 32'(bus_a.wave), 0);
    chk("arst_steal", 32'(bus_a.steal), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
